// File: rtl/comp_8_if.sv
`default_nettype none
// ============================================================================
//  Module      : comp_8_if
//  Description : Operand/flag bundle for the comp_8 registered comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface comp_8_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  gt;
  logic                  lt;
  logic                  eq;

  modport master (output A, output B, input gt, input lt, input eq);
  modport slave  (input A, input B, output gt, output lt, output eq);
endinterface
`default_nettype wire

// File: rtl/comp_8.sv
`default_nettype none
// ============================================================================
//  Module      : comp_8
//  Description : Registered magnitude comparator, one-cycle latency, one-hot
//                gt/lt/eq flags (all zero while in reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module comp_8 #(
  parameter int DATA_WIDTH = 8,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  comp_8_if.slave   bus_io
);

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  localparam logic [DATA_WIDTH-1:0] C_MSB_FLIP =
    SIGNED_CMP ? (DATA_WIDTH'(1) << (DATA_WIDTH - 1)) : '0;

  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;
  logic [DATA_WIDTH:0]   w_gt_chain;
  logic [DATA_WIDTH:0]   w_eq_chain;

  logic gt_d, lt_d, eq_d;
  logic gt_q, lt_q, eq_q;

  assign w_a = bus_io.A ^ C_MSB_FLIP;
  assign w_b = bus_io.B ^ C_MSB_FLIP;

  assign w_gt_chain[DATA_WIDTH] = 1'b0;
  assign w_eq_chain[DATA_WIDTH] = 1'b1;

  // Each stage only decides when every higher bit has compared equal.
  genvar i;
  generate
    for (i = DATA_WIDTH - 1; i >= 0; i--) begin : g_cascade
      assign w_gt_chain[i] = w_gt_chain[i+1] | (w_eq_chain[i+1] & w_a[i] & ~w_b[i]);
      assign w_eq_chain[i] = w_eq_chain[i+1] & ~(w_a[i] ^ w_b[i]);
    end
  endgenerate

  always_comb begin
    gt_d = w_gt_chain[0];
    eq_d = w_eq_chain[0];
    lt_d = ~w_gt_chain[0] & ~w_eq_chain[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gt_q <= 1'b0;
      lt_q <= 1'b0;
      eq_q <= 1'b0;
    end else begin
      gt_q <= gt_d;
      lt_q <= lt_d;
      eq_q <= eq_d;
    end
  end

  assign bus_io.gt = gt_q;
  assign bus_io.lt = lt_q;
  assign bus_io.eq = eq_q;

endmodule
`default_nettype wire

// File: tb/tb_comp_8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comp_8
//  Description : Directed and random checks of comp_8 across widths and modes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comp_8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  comp_8_if #(.DATA_WIDTH(8))  if_u8  ();
  comp_8_if #(.DATA_WIDTH(8))  if_s8  ();
  comp_8_if #(.DATA_WIDTH(16)) if_u16 ();
  comp_8_if #(.DATA_WIDTH(16)) if_s16 ();
  comp_8_if #(.DATA_WIDTH(1))  if_u1  ();
  comp_8_if #(.DATA_WIDTH(1))  if_s1  ();

  comp_8 #(.DATA_WIDTH(8),  .SIGNED_CMP(1'b0)) u_u8  (.clk(clk), .rst(rst), .bus_io(if_u8));
  comp_8 #(.DATA_WIDTH(8),  .SIGNED_CMP(1'b1)) u_s8  (.clk(clk), .rst(rst), .bus_io(if_s8));
  comp_8 #(.DATA_WIDTH(16), .SIGNED_CMP(1'b0)) u_u16 (.clk(clk), .rst(rst), .bus_io(if_u16));
  comp_8 #(.DATA_WIDTH(16), .SIGNED_CMP(1'b1)) u_s16 (.clk(clk), .rst(rst), .bus_io(if_s16));
  comp_8 #(.DATA_WIDTH(1),  .SIGNED_CMP(1'b0)) u_u1  (.clk(clk), .rst(rst), .bus_io(if_u1));
  comp_8 #(.DATA_WIDTH(1),  .SIGNED_CMP(1'b1)) u_s1  (.clk(clk), .rst(rst), .bus_io(if_s1));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: gt/lt/eq got %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b);
    if_u8.A  = a[7:0];  if_u8.B  = b[7:0];
    if_s8.A  = a[7:0];  if_s8.B  = b[7:0];
    if_u16.A = a;       if_u16.B = b;
    if_s16.A = a;       if_s16.B = b;
    if_u1.A  = a[0];    if_u1.B  = b[0];
    if_s1.A  = a[0];    if_s1.B  = b[0];
  endtask

  function automatic logic [2:0] ref_cmp(input logic [15:0] a, input logic [15:0] b,
                                         input int w, input bit sgn);
    longint m;
    longint va;
    longint vb;
    m  = (longint'(1) << w) - 1;
    va = longint'(a) & m;
    vb = longint'(b) & m;
    if (sgn && va[w-1]) va = va - (longint'(1) << w);
    if (sgn && vb[w-1]) vb = vb - (longint'(1) << w);
    if (va > vb)      return 3'b100;
    else if (va < vb) return 3'b010;
    else              return 3'b001;
  endfunction

  task automatic chk_dut(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    chk(tag, obs, exp);
    chk({tag, "_onehot"}, {2'b00, $onehot(obs)}, 3'b001);
  endtask

  task automatic check_all(input logic [15:0] a, input logic [15:0] b);
    chk_dut("rnd_u8",  {if_u8.gt,  if_u8.lt,  if_u8.eq},  ref_cmp(a, b, 8,  1'b0));
    chk_dut("rnd_s8",  {if_s8.gt,  if_s8.lt,  if_s8.eq},  ref_cmp(a, b, 8,  1'b1));
    chk_dut("rnd_u16", {if_u16.gt, if_u16.lt, if_u16.eq}, ref_cmp(a, b, 16, 1'b0));
    chk_dut("rnd_s16", {if_s16.gt, if_s16.lt, if_s16.eq}, ref_cmp(a, b, 16, 1'b1));
    chk_dut("rnd_u1",  {if_u1.gt,  if_u1.lt,  if_u1.eq},  ref_cmp(a, b, 1,  1'b0));
    chk_dut("rnd_s1",  {if_s1.gt,  if_s1.lt,  if_s1.eq},  ref_cmp(a, b, 1,  1'b1));
  endtask

  // Directed step: apply 8-bit operands, then check both 8-bit DUTs one edge later.
  task automatic step8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] exp_u, input logic [2:0] exp_s);
    drive({8'h00, a}, {8'h00, b});
    tick();
    chk({tag, "_u"}, {if_u8.gt, if_u8.lt, if_u8.eq}, exp_u);
    chk({tag, "_s"}, {if_s8.gt, if_s8.lt, if_s8.eq}, exp_s);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;

    drive(16'h0055, 16'h0000);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_u8", {if_u8.gt, if_u8.lt, if_u8.eq}, 3'b000);
    chk("rst_async_s8", {if_s8.gt, if_s8.lt, if_s8.eq}, 3'b000);
    tick();
    chk("rst_held_u8", {if_u8.gt, if_u8.lt, if_u8.eq}, 3'b000);
    rst = 1'b0;
    tick();
    chk("rst_rel_u8", {if_u8.gt, if_u8.lt, if_u8.eq}, 3'b100);
    chk("rst_rel_s8", {if_s8.gt, if_s8.lt, if_s8.eq}, 3'b100);

    // Consecutive steps also exercise back-to-back throughput.
    step8("eq_00",  8'h00, 8'h00, 3'b001, 3'b001);
    step8("eq_ff",  8'hFF, 8'hFF, 3'b001, 3'b001);
    step8("gt_80",  8'h80, 8'h00, 3'b100, 3'b010);
    step8("gt_lsb", 8'h01, 8'h00, 3'b100, 3'b100);
    step8("lt_80",  8'h00, 8'h80, 3'b010, 3'b100);
    step8("lt_7f",  8'h7F, 8'h80, 3'b010, 3'b100);
    step8("ff_fe",  8'hFF, 8'hFE, 3'b100, 3'b100);
    step8("fe_ff",  8'hFE, 8'hFF, 3'b010, 3'b010);

    // Reset between edges: in-flight operands are discarded.
    drive(16'h0001, 16'h0002);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_u8",  {if_u8.gt,  if_u8.lt,  if_u8.eq},  3'b000);
    chk("rst_mid_u16", {if_u16.gt, if_u16.lt, if_u16.eq}, 3'b000);
    tick();
    chk("rst_mid_edge", {if_s8.gt, if_s8.lt, if_s8.eq}, 3'b000);
    rst = 1'b0;
    step8("post_rst_eq", 8'h03, 8'h03, 3'b001, 3'b001);

    for (int i = 0; i < 1200; i++) begin
      ra = 16'($urandom);
      rb = (i % 5 == 0) ? ra : 16'($urandom);
      drive(ra, rb);
      tick();
      check_all(ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
